// File: rtl/noc_c2m_arbiter.sv
// rtl/noc_c2m_arbiter.sv - round-robin C2M port arbiter with in-order M2C response steering
// Optional macro C2M_ARB_STATS_EN adds saturating per-core grant counters (grant_cnt).
module noc_c2m_arbiter #(
  parameter int RADIX           = 2,
  parameter int BIT_WIDTH       = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [RADIX-1:0]                    en_C2M_IN,
  input  logic [RADIX*BIT_WIDTH-1:0]          Data_C2M_IN,
  input  logic [RADIX*ADDR_WIDTH-1:0]         Addr_C2M_IN,
  output logic [RADIX-1:0]                    rdy_C2M_IN,
  output logic                                en_C2M_OUT,
  output logic [BIT_WIDTH-1:0]                Data_C2M_OUT,
  output logic [ADDR_WIDTH-1:0]               Addr_C2M_OUT,
  input  logic                                mem_rdy,
  input  logic                                en_M2C_IN,
  output logic [RADIX-1:0]                    sel_M2C_OUT,
  output logic [$clog2(MAX_OUTSTANDING):0]    outstanding,
  output logic                                err_underflow
`ifdef C2M_ARB_STATS_EN
  ,
  output logic [15:0]                         grant_cnt [RADIX]
`endif
);

  localparam int IDW = $clog2(RADIX);
  localparam int AW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW  = $clog2(MAX_OUTSTANDING) + 1;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win_idx;
  logic           win_found;
  logic           out_free;
  logic           grant;
  logic           pop;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [IDW-1:0] id_mem [MAX_OUTSTANDING];

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < RADIX; k++) begin
      if (!win_found && en_C2M_IN[(int'(rr_ptr) + k) % RADIX]) begin
        win_found = 1'b1;
        win_idx   = IDW'((int'(rr_ptr) + k) % RADIX);
      end
    end
  end

  // Full check uses registered occupancy, so a same-cycle pop never frees a slot.
  assign out_free    = !en_C2M_OUT || mem_rdy;
  assign grant       = out_free && (outstanding < CW'(MAX_OUTSTANDING)) && win_found;
  assign rdy_C2M_IN  = grant ? (RADIX'(1) << win_idx) : '0;
  assign pop         = en_M2C_IN && (outstanding != '0);
  assign sel_M2C_OUT = pop ? (RADIX'(1) << id_mem[rd_ptr]) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_C2M_OUT    <= 1'b0;
      Data_C2M_OUT  <= '0;
      Addr_C2M_OUT  <= '0;
      rr_ptr        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (grant) begin
        en_C2M_OUT   <= 1'b1;
        Data_C2M_OUT <= Data_C2M_IN[win_idx*BIT_WIDTH +: BIT_WIDTH];
        Addr_C2M_OUT <= Addr_C2M_IN[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
        rr_ptr       <= (win_idx == IDW'(RADIX - 1)) ? '0 : win_idx + 1'b1;
        wr_ptr       <= next_ptr(wr_ptr);
      end else if (mem_rdy) begin
        en_C2M_OUT   <= 1'b0;
      end
      if (pop)
        rd_ptr <= next_ptr(rd_ptr);
      if (en_M2C_IN && (outstanding == '0))
        err_underflow <= 1'b1;
      outstanding <= outstanding + CW'(grant) - CW'(pop);
    end
  end

  // Entries need no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (grant)
      id_mem[wr_ptr] <= win_idx;
  end

`ifdef C2M_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RADIX; i++)
        grant_cnt[i] <= '0;
    end else if (grant && (grant_cnt[win_idx] != 16'hFFFF)) begin
      grant_cnt[win_idx] <= grant_cnt[win_idx] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_c2m_arbiter.sv
// tb/tb_noc_c2m_arbiter.sv - bench for noc_c2m_arbiter
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_noc_c2m_arbiter;

  localparam int RADIX = 2;
  localparam int BW    = 32;
  localparam int AWD   = 32;
  localparam int MAXO  = 4;
  localparam int CW    = $clog2(MAXO) + 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [RADIX-1:0]      en_C2M_IN;
  logic [RADIX*BW-1:0]   Data_C2M_IN;
  logic [RADIX*AWD-1:0]  Addr_C2M_IN;
  logic [RADIX-1:0]      rdy_C2M_IN;
  logic                  en_C2M_OUT;
  logic [BW-1:0]         Data_C2M_OUT;
  logic [AWD-1:0]        Addr_C2M_OUT;
  logic                  mem_rdy;
  logic                  en_M2C_IN;
  logic [RADIX-1:0]      sel_M2C_OUT;
  logic [CW-1:0]         outstanding;
  logic                  err_underflow;
`ifdef C2M_ARB_STATS_EN
  logic [15:0]           grant_cnt [RADIX];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  noc_c2m_arbiter #(
    .RADIX(RADIX), .BIT_WIDTH(BW), .ADDR_WIDTH(AWD), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .en_C2M_IN(en_C2M_IN), .Data_C2M_IN(Data_C2M_IN), .Addr_C2M_IN(Addr_C2M_IN),
    .rdy_C2M_IN(rdy_C2M_IN), .en_C2M_OUT(en_C2M_OUT), .Data_C2M_OUT(Data_C2M_OUT),
    .Addr_C2M_OUT(Addr_C2M_OUT), .mem_rdy(mem_rdy), .en_M2C_IN(en_M2C_IN),
    .sel_M2C_OUT(sel_M2C_OUT), .outstanding(outstanding), .err_underflow(err_underflow)
`ifdef C2M_ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    en_C2M_IN   = '0;
    Data_C2M_IN = '0;
    Addr_C2M_IN = '0;
    mem_rdy     = 1'b0;
    en_M2C_IN   = 1'b0;
    rst         = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    en_C2M_IN = 2'b01;
    Data_C2M_IN[0 +: BW]  = 32'hDEADBEEF;
    Addr_C2M_IN[0 +: AWD] = 32'h00001234;
    mem_rdy = 1'b1;
    @(posedge clk); #1;
    en_C2M_IN = '0;
    mem_rdy   = 1'b0;
    n_checks++;
    if (en_C2M_OUT !== 1'b1) begin n_fail++; $display("FAIL reset_pre_en: got %b expected 1", en_C2M_OUT); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (en_C2M_OUT !== 1'b0) begin n_fail++; $display("FAIL reset_en_out: got %b expected 0", en_C2M_OUT); end
    n_checks++;
    if (Data_C2M_OUT !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", Data_C2M_OUT); end
    n_checks++;
    if (Addr_C2M_OUT !== '0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", Addr_C2M_OUT); end
    n_checks++;
    if (outstanding !== '0) begin n_fail++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    n_checks++;
    if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_underflow); end
    n_checks++;
    if (rdy_C2M_IN !== '0 || sel_M2C_OUT !== '0) begin
      n_fail++; $display("FAIL reset_rdy_sel: got rdy=%b sel=%b expected 00/00", rdy_C2M_IN, sel_M2C_OUT);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    apply_reset();
    en_C2M_IN = 2'b01;
    Addr_C2M_IN[0 +: AWD] = 32'h0000FFFF;
    mem_rdy = 1'b1;
    #1;
    n_checks++;
    if (rdy_C2M_IN !== 2'b01) begin n_fail++; $display("FAIL single_rdy: got %b expected 01", rdy_C2M_IN); end
    @(posedge clk); #1;
    en_C2M_IN = '0;
    n_checks++;
    if (en_C2M_OUT !== 1'b1) begin n_fail++; $display("FAIL single_en_out: got %b expected 1", en_C2M_OUT); end
    n_checks++;
    if (Addr_C2M_OUT !== 32'h0000FFFF) begin n_fail++; $display("FAIL single_addr: got %h expected 0000ffff", Addr_C2M_OUT); end
    n_checks++;
    if (outstanding !== CW'(1)) begin n_fail++; $display("FAIL single_outstanding: got %0d expected 1", outstanding); end
  endtask

  task automatic test_fairness();
    logic [RADIX-1:0] exp_rdy;
    apply_reset();
    en_C2M_IN = 2'b11;
    mem_rdy   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      exp_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_checks++;
      if (rdy_C2M_IN !== exp_rdy) begin n_fail++; $display("FAIL fair_rdy[%0d]: got %b expected %b", c, rdy_C2M_IN, exp_rdy); end
      @(posedge clk); #1;
      n_checks++;
      if (en_C2M_OUT !== 1'b1) begin n_fail++; $display("FAIL fair_en_out[%0d]: got %b expected 1", c, en_C2M_OUT); end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (outstanding !== CW'(4)) begin n_fail++; $display("FAIL fair_outstanding: got %0d expected 4", outstanding); end
    n_checks++;
    if (rdy_C2M_IN !== 2'b00) begin n_fail++; $display("FAIL fair_full_rdy: got %b expected 00", rdy_C2M_IN); end
`ifdef C2M_ARB_STATS_EN
    n_checks++;
    if (grant_cnt[0] !== 16'd2 || grant_cnt[1] !== 16'd2) begin
      n_fail++; $display("FAIL fair_grant_cnt: got %0d/%0d expected 2/2", grant_cnt[0], grant_cnt[1]);
    end
`endif
    en_C2M_IN = '0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    en_C2M_IN = 2'b01;
    Data_C2M_IN[0 +: BW]  = 32'hAAAA0001;
    Data_C2M_IN[BW +: BW] = 32'hCCCC0003;
    mem_rdy = 1'b1;
    @(posedge clk); #1;
    mem_rdy = 1'b0;
    en_C2M_IN = 2'b11;
    Data_C2M_IN[0 +: BW] = 32'hBBBB0002;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if (rdy_C2M_IN !== 2'b00) begin n_fail++; $display("FAIL bp_rdy[%0d]: got %b expected 00", c, rdy_C2M_IN); end
      @(posedge clk); #1;
      n_checks++;
      if (Data_C2M_OUT !== 32'hAAAA0001 || en_C2M_OUT !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got en=%b data=%h expected 1/aaaa0001", c, en_C2M_OUT, Data_C2M_OUT);
      end
    end
    @(negedge clk);
    mem_rdy = 1'b1;
    #1;
    n_checks++;
    if (rdy_C2M_IN !== 2'b10) begin n_fail++; $display("FAIL bp_resume_rdy: got %b expected 10", rdy_C2M_IN); end
    @(posedge clk); #1;
    en_C2M_IN = '0;
    n_checks++;
    if (Data_C2M_OUT !== 32'hCCCC0003) begin n_fail++; $display("FAIL bp_resume_data: got %h expected cccc0003", Data_C2M_OUT); end
  endtask

  task automatic test_routing();
    apply_reset();
    mem_rdy   = 1'b1;
    en_C2M_IN = 2'b10;
    @(negedge clk);
    en_C2M_IN = 2'b01;
    @(negedge clk);
    en_C2M_IN = '0;
    n_checks++;
    if (outstanding !== CW'(2)) begin n_fail++; $display("FAIL route_outstanding2: got %0d expected 2", outstanding); end
    en_M2C_IN = 1'b1;
    #1;
    n_checks++;
    if (sel_M2C_OUT !== 2'b10) begin n_fail++; $display("FAIL route_sel1: got %b expected 10", sel_M2C_OUT); end
    @(posedge clk); #1;
    n_checks++;
    if (sel_M2C_OUT !== 2'b01 || outstanding !== CW'(1)) begin
      n_fail++; $display("FAIL route_sel2: got sel=%b out=%0d expected 01/1", sel_M2C_OUT, outstanding);
    end
    @(posedge clk); #1;
    en_M2C_IN = 1'b0;
    n_checks++;
    if (outstanding !== CW'(0) || err_underflow !== 1'b0) begin
      n_fail++; $display("FAIL route_drained: got out=%0d err=%b expected 0/0", outstanding, err_underflow);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    en_M2C_IN = 1'b1;
    #1;
    n_checks++;
    if (sel_M2C_OUT !== 2'b00) begin n_fail++; $display("FAIL uf_sel: got %b expected 00", sel_M2C_OUT); end
    @(posedge clk); #1;
    en_M2C_IN = 1'b0;
    n_checks++;
    if (err_underflow !== 1'b1 || outstanding !== CW'(0)) begin
      n_fail++; $display("FAIL uf_set: got err=%b out=%0d expected 1/0", err_underflow, outstanding);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b expected 1", err_underflow); end
  endtask

  task automatic test_random();
    int               m_rr;
    bit               m_en;
    logic [BW-1:0]    m_data;
    logic [AWD-1:0]   m_addr;
    int               q[$];
    bit               m_err;
    int               m_cnt [RADIX];
    int               g;
    logic [RADIX-1:0] exp_rdy, exp_sel;
    apply_reset();
    m_rr = 0; m_en = 0; m_data = '0; m_addr = '0; m_err = 0; q.delete();
    for (int i = 0; i < RADIX; i++) m_cnt[i] = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      en_C2M_IN = RADIX'($urandom);
      for (int i = 0; i < RADIX; i++) begin
        Data_C2M_IN[i*BW +: BW]   = $urandom;
        Addr_C2M_IN[i*AWD +: AWD] = $urandom;
      end
      mem_rdy   = ($urandom_range(0, 3) != 0);
      en_M2C_IN = (q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      #1;
      g = -1;
      if ((!m_en || mem_rdy) && q.size() < MAXO) begin
        for (int k = 0; k < RADIX; k++) begin
          if (en_C2M_IN[(m_rr + k) % RADIX]) begin g = (m_rr + k) % RADIX; break; end
        end
      end
      exp_rdy = (g >= 0) ? (RADIX'(1) << g) : '0;
      exp_sel = (en_M2C_IN && q.size() > 0) ? (RADIX'(1) << q[0]) : '0;
      n_checks++;
      if (rdy_C2M_IN !== exp_rdy) begin n_fail++; $display("FAIL rand_rdy[%0d]: got %b expected %b", c, rdy_C2M_IN, exp_rdy); end
      n_checks++;
      if (sel_M2C_OUT !== exp_sel) begin n_fail++; $display("FAIL rand_sel[%0d]: got %b expected %b", c, sel_M2C_OUT, exp_sel); end
      if (en_M2C_IN) begin
        if (q.size() > 0) void'(q.pop_front());
        else m_err = 1;
      end
      if (g >= 0) begin
        q.push_back(g);
        m_en   = 1;
        m_data = Data_C2M_IN[g*BW +: BW];
        m_addr = Addr_C2M_IN[g*AWD +: AWD];
        m_rr   = (g + 1) % RADIX;
        if (m_cnt[g] < 16'hFFFF) m_cnt[g]++;
      end else if (mem_rdy) begin
        m_en = 0;
      end
      @(posedge clk); #1;
      n_checks++;
      if (en_C2M_OUT !== m_en || Data_C2M_OUT !== m_data || Addr_C2M_OUT !== m_addr) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: got en=%b d=%h a=%h expected en=%b d=%h a=%h",
                 c, en_C2M_OUT, Data_C2M_OUT, Addr_C2M_OUT, m_en, m_data, m_addr);
      end
      n_checks++;
      if (outstanding !== CW'(q.size()) || err_underflow !== m_err) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: got out=%0d err=%b expected out=%0d err=%b",
                 c, outstanding, err_underflow, q.size(), m_err);
      end
`ifdef C2M_ARB_STATS_EN
      for (int i = 0; i < RADIX; i++) begin
        n_checks++;
        if (grant_cnt[i] !== 16'(m_cnt[i])) begin
          n_fail++; $display("FAIL rand_grant_cnt[%0d][%0d]: got %0d expected %0d", c, i, grant_cnt[i], m_cnt[i]);
        end
      end
`endif
    end
    en_C2M_IN = '0;
    en_M2C_IN = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en_C2M_IN = '0; Data_C2M_IN = '0; Addr_C2M_IN = '0;
    mem_rdy = 1'b0; en_M2C_IN = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_routing();
    test_underflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
